// File: rtl/hex_display_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_pkg
// Description : Shared constants and helpers for the hex display scanner.
//               Holds the active-high 7-segment glyph table (bit0=a .. bit6=g),
//               the "all segments dark" pattern and the polarity helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

    // Segment pattern with every segment dark, active-high.
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high glyphs for 0..F, bit order g..a.
    localparam logic [6:0] SEG_PATTERNS [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Converts an active-high {dp, seg} vector to the pin polarity.
    function automatic logic [7:0] apply_polarity(input logic [7:0] lit,
                                                  input logic       active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_display_scanner_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : scan_prescaler
// Description : Free-running DIV-bit refresh counter. Emits a one-cycle tick
//               while the counter sits at its terminal value, i.e. on the
//               cycle whose closing edge wraps the count back to zero.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset (count returns to 0)
//               tick - wrap pulse, one cycle every 2^DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [DIV-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Terminal count: the next edge wraps to zero.
    assign tick = &r_count;

endmodule
`default_nettype wire

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner
// Description : Time-multiplexed driver for DIGITS common-anode 7-segment
//               digits sharing one segment bus. Keeps a shadow copy of the
//               hex nibbles, decimal points and leading-zero-blank flag,
//               and scans one digit per 2^DIV-cycle refresh slot.
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset
//               load     - capture values/dp/blank_lz into the shadow
//               values   - hex nibbles, digit i = values[4i+3:4i]
//               dp       - decimal point request per digit (1 = lit)
//               blank_lz - 1 = suppress leading zeros
//               seg      - segments a..g (bit0..bit6), pin polarity
//               dp_out   - decimal point, same polarity as seg
//               sel      - one-hot digit select, pin polarity
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV            = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   values,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     sel
);

    localparam int               IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [7:0]       C_DARK     = apply_polarity({1'b0, SEG_OFF}, SEG_ACTIVE_LOW);
    localparam logic [DIGITS-1:0] C_SEL_OFF = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // ------------------------------------------------------------------------
    // Refresh slot timing
    // ------------------------------------------------------------------------
    logic w_tick;

    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow register: the display only ever reads these copies
    // ------------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_values;
    logic [DIGITS-1:0]   r_dp;
    logic                r_blank_lz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_values   <= '0;
            r_dp       <= '0;
            r_blank_lz <= 1'b0;
        end else if (load) begin
            r_values   <= values;
            r_dp       <= dp;
            r_blank_lz <= blank_lz;
        end
    end

    // ------------------------------------------------------------------------
    // Current digit decode
    // ------------------------------------------------------------------------
    logic [3:0]        w_nib;
    logic              w_dp_req;
    logic              w_upper_zero;
    logic              w_blank;
    logic [DIGITS-1:0] w_sel_hi;
    logic [7:0]        w_lit;
    logic [7:0]        w_pins;

    always_comb begin
        w_nib        = 4'h0;
        w_dp_req     = 1'b0;
        w_upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_nib    = r_values[4*i +: 4];
                w_dp_req = r_dp[i];
            end
            // Digit idx is a leading zero only if it and every more
            // significant nibble are all zero.
            if ((i >= int'(r_idx)) && (r_values[4*i +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    // Digit 0 always shows, so a value of zero still reads "0".
    assign w_blank = r_blank_lz && (r_idx != '0) && w_upper_zero;

    always_comb begin
        w_sel_hi = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_sel_hi[i] = (IDX_W'(i) == r_idx) && !w_blank;
        end
    end

    assign w_lit  = w_blank ? {1'b0, SEG_OFF} : {w_dp_req, SEG_PATTERNS[w_nib]};
    assign w_pins = apply_polarity(w_lit, SEG_ACTIVE_LOW);

    // ------------------------------------------------------------------------
    // Registered pin drivers
    // ------------------------------------------------------------------------
    logic [6:0]        r_seg;
    logic              r_dp_out;
    logic [DIGITS-1:0] r_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg    <= C_DARK[6:0];
            r_dp_out <= C_DARK[7];
            r_sel    <= C_SEL_OFF;
        end else begin
            r_seg    <= w_pins[6:0];
            r_dp_out <= w_pins[7];
            r_sel    <= SEL_ACTIVE_LOW ? ~w_sel_hi : w_sel_hi;
        end
    end

    assign seg    = r_seg;
    assign dp_out = r_dp_out;
    assign sel    = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_display_scanner
// Description : Self-checking bench for hex_display_scanner (DIGITS=4, DIV=4,
//               active-low segments and selects). A reference model derives
//               the expected pins from cycles-since-reset and the shadow
//               contents; expectations are queued and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_scanner;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int SLOT   = 1 << DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] values = '0;
    logic [3:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  sel;

    hex_display_scanner #(
        .DIGITS         (DIGITS),
        .DIV            (DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .values   (values),
        .dp       (dp),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp_out   (dp_out),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got sel=%b dp=%b seg=%b, want sel=%b dp=%b seg=%b",
                     name, act[11:8], act[7], act[6:0], exp[11:8], exp[7], exp[6:0]);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: glyphs g..a for 0..F, lit = 1
    // ------------------------------------------------------------------------
    logic [6:0] glyph [0:15] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    localparam logic [11:0] DARK = {4'hF, 1'b1, 7'h7F};

    function automatic logic [11:0] model_out(input int cyc, input logic [15:0] v,
                                              input logic [3:0] d, input logic b);
        int         idx;
        logic [15:0] upper;
        logic [3:0]  nib;
        idx   = (cyc / SLOT) % DIGITS;
        upper = v >> (4 * idx);
        nib   = upper[3:0];
        if (b && idx > 0 && upper == 16'h0) return DARK;
        return {~(4'b0001 << idx), ~d[idx], ~glyph[nib]};
    endfunction

    logic [11:0] exp_q [$];
    int          m_cyc     = 0;
    logic [15:0] m_values  = '0;
    logic [3:0]  m_dp      = '0;
    logic        m_blz     = 1'b0;
    bit          m_started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.push_back(DARK);
            m_cyc     = 0;
            m_values  = '0;
            m_dp      = '0;
            m_blz     = 1'b0;
            m_started = 1'b1;
        end else if (m_started) begin
            exp_q.push_back(model_out(m_cyc, m_values, m_dp, m_blz));
            if (load) begin
                m_values = values;
                m_dp     = dp;
                m_blz    = blank_lz;
            end
            m_cyc++;
        end
    end

    // Monitor: every edge presents a fresh registered output.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            check("scoreboard", {sel, dp_out, seg}, exp_q.pop_front());
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        load     = 1'b1;
        values   = v;
        dp       = d;
        blank_lz = b;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        logic [11:0] scan_exp [0:4];
        scan_exp[0] = {4'b1110, 1'b1, 7'b0001110};
        scan_exp[1] = {4'b1101, 1'b1, 7'b0001000};
        scan_exp[2] = {4'b1011, 1'b1, 7'b0100100};
        scan_exp[3] = {4'b0111, 1'b1, 7'b1111001};
        scan_exp[4] = {4'b1110, 1'b1, 7'b0001110};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pins", {sel, dp_out, seg}, DARK);

        // Release reset while loading 12AF; digit 0 shows F two edges later.
        rst = 1'b0;
        do_load(16'h12AF, 4'b0000, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("scan_digit_%0d", k), {sel, dp_out, seg}, scan_exp[k]);
            repeat (SLOT) @(negedge clk);
        end

        // Leading-zero, decimal-point and mid-scan load patterns.
        do_load(16'h0040, 4'b0000, 1'b1);
        repeat (4 * SLOT) @(negedge clk);
        do_load(16'h0000, 4'b0100, 1'b1);
        repeat (4 * SLOT) @(negedge clk);
        do_load(16'h1234, 4'b0100, 1'b0);
        repeat (40) @(negedge clk);
        do_load(16'h1934, 4'b0100, 1'b0);
        repeat (30) @(negedge clk);

        // Randomized loads and occasional reset pulses.
        for (int c = 0; c < 4000; c++) begin
            rst  = ($urandom_range(0, 149) == 0);
            load = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       values = 16'h0000;
                1:       values = 16'($urandom_range(0, 255));
                2:       values = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
                default: values = 16'($urandom);
            endcase
            dp       = 4'($urandom);
            blank_lz = 1'($urandom);
            @(negedge clk);
        end
        rst  = 1'b0;
        load = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed driver for a bank of common-anode 7-segment digits on the IO shield. It holds a shadow copy of DIGITS hex nibbles plus decimal points and scans them onto one shared segment bus, one digit per refresh slot. Decode, optional leading-zero blanking and polarity handling are built in. It sits between application logic, which loads values, and the board pins.

## Interface
- DIGITS, 4: number of digits scanned, 1..8.
- DIV, 16: refresh prescaler width; the digit slot lasts 2^DIV clk cycles.
- SEG_ACTIVE_LOW, 1: 1 = segment/dp lit when driven 0.
- SEL_ACTIVE_LOW, 1: 1 = digit enabled when its select is driven 0.
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain, reset is synchronous and active-high.
- load  in  1  strobe; captures values/dp/blank_lz into the shadow register.
- values  in  4*DIGITS  hex nibbles; digit i = values[4i+3:4i]; digit 0 is rightmost.
- dp  in  DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros.
- seg  out  7  segments, bit0=a … bit6=g, polarity per SEG_ACTIVE_LOW.
- dp_out  out  1  decimal point, same polarity as seg.
- sel  out  DIGITS  one-hot digit enable, polarity per SEL_ACTIVE_LOW.

## Operation
- Shadow register (values, dp, blank_lz) loads on any clk edge with load=1. The display reads only the shadow; inputs are ignored otherwise.
- Prescaler counts 0..2^DIV-1 and wraps. At wrap, digit index idx advances 0→1→…→DIGITS-1→0.
- Decode (active-high, before polarity), bits g..a: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Leading-zero blank: digit i (i>0) is blanked when blank_lz=1 and all shadow nibbles i..DIGITS-1 are 0. Digit 0 is never blanked.
  - A blanked digit drives seg off, dp_out off and its sel inactive.
  - Its dp request is ignored.
- dp_out is lit iff dp[idx] of the shadow is set and the digit is not blanked.
- Exactly one sel bit is active per cycle unless the current digit is blanked, in which case none are active.
- DIGITS=1: idx stays 0; the prescaler still runs.

## Timing
- seg, dp_out and sel are registered, one cycle after (idx, shadow).
  - Load at edge N is visible on outputs at edge N+1 if idx matches.
  - An idx change at edge N is visible at edge N+1.
- Reset values, one cycle after rst sampled high:
  - prescaler=0, idx=0, shadow=0, blank_lz shadow=0.
  - seg all off (7'h7F when active-low), dp_out off, sel all inactive.
- First post-reset output is digit 0 showing "0", at edge 2 after rst deasserts.
- rst mid-scan overrides load in the same cycle; scanning restarts from idx 0 with a full slot.
- load and prescaler wrap in the same cycle: both take effect. The new digit shows the new shadow on the next edge.

## Structure
- Package hex_display_pkg:
  - 16-entry active-high segment pattern constant.
  - SEG_OFF constant.
  - Function applying polarity.
- Sub-module scan_prescaler (parameter DIV, ports clk, rst, tick) generates the one-cycle wrap pulse. Everything else lives in hex_display_scanner.

## Test plan
All scenarios use DIGITS=4, DIV=4, both polarities active-low.
- Reset: rst high 3 cycles → seg=7'h7F, dp_out=1, sel=4'hF; idx=0 after release.
- Scan: load values=16'h12AF, dp=0, blank_lz=0.
  - Digit 0: seg=7'b0001110, sel=4'b1110.
  - After 16 cycles: seg=7'b0001000, sel=4'b1101.
  - Then 7'b0100100 / 4'b1011, then 7'b1111001 / 4'b0111.
  - Wraps to digit 0 after 64 cycles.
- Leading zeros: load values=16'h0040 with blank_lz=1.
  - Digits 3 and 2: seg=7'h7F, sel=4'hF.
  - Digit 1: 7'b0011001. Digit 0: 7'b1000000.
  - values=16'h0000 → only digit 0 lit, showing 0.
- DP: load dp=4'b0100 → dp_out=0 only while sel=4'b1011.
  - With values=16'h0000 and blank_lz=1, dp_out stays 1 throughout.
- Mid-scan load: while idx=2 showing values 16'h1234, load 16'h1934 → seg=7'b0010000 on the next edge, sel unchanged.
- Mid-scan reset: rst pulsed at idx=3, prescaler=7, load also high → next edge gives reset outputs and shadow=0; digit 0 slot then lasts a full 16 cycles.
